mem_io_bridge: RTL and testbench

- Parametrised load/store bridge between the CPU memory stage, data memory (dMem) and the board I/O: switches, keypad, confirm button, LEDs and 7-segment display.
- Decodes the effective address and stalls the CPU for a configurable synchronous-memory read latency.
- Handles byte/half/word stores with byte enables, and sign/zero extension on loads.
- Owns the registered LED/Seg output latches and a sticky, clear-on-read confirm-button flag.

---
 rtl/mem_io_pkg.sv | 30 +++
 rtl/mem_io_bridge_load_extend.sv | 30 +++
 rtl/mem_io_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_mem_io_bridge.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// Shared constants for the load/store bridge: I/O address map, access-size
// encodings, load FSM states and the alignment rule.
package mem_io_pkg;

    localparam logic [31:0] ADDR_LED    = 32'hFFFF_FC60;
    localparam logic [31:0] ADDR_SEG    = 32'hFFFF_FC64;
    localparam logic [31:0] ADDR_SWITCH = 32'hFFFF_FC70;
    localparam logic [31:0] ADDR_KEY    = 32'hFFFF_FC74;
    localparam logic [31:0] ADDR_BTN    = 32'hFFFF_FC78;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;   // 2'b11 is decoded as a word too

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Half accesses need an even address, word accesses a multiple of four.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] low);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return low[0];
            default: return (low != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_io_bridge_load_extend.sv
// Load lane selection and sign/zero extension, shared by memory and I/O reads.
module load_extend
    import mem_io_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data_in,
    input  logic [1:0]        byte_off,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] data_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane and widen it to the full register width.
    always_comb begin
        byte_sel = data_in[{byte_off, 3'b000} +: 8];
        half_sel = data_in[{byte_off[1], 4'b0000} +: 16];
        case (size)
            SZ_B:    data_out = is_unsigned ? DATA_W'(byte_sel)
                                            : {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            SZ_H:    data_out = is_unsigned ? DATA_W'(half_sel)
                                            : {{(DATA_W-16){half_sel[15]}}, half_sel};
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/mem_io_bridge.sv
// CPU memory-stage bridge: address decode, dMem load stall FSM, byte-enabled
// stores, and the board I/O registers (LED, segment, switch, keypad, button).
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1,     // 1..4
    parameter int SW_W    = 12,
    parameter int KEY_W   = 4,
    parameter int LED_W   = 16,
    parameter int SEG_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mRead,
    input  logic              mWrite,
    input  logic              ioRead,
    input  logic              ioWrite,
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    input  logic [DATA_W-1:0] addr_in,
    input  logic [DATA_W-1:0] r_rdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [SW_W-1:0]   switch_raw,
    input  logic [KEY_W-1:0]  key_data,
    input  logic              key_valid,
    input  logic              conf_btn,
    output logic [DATA_W-1:0] addr_out,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_be,
    output logic [DATA_W-1:0] r_wdata,
    output logic              stall,
    output logic              misalign,
    output logic [LED_W-1:0]  led_out,
    output logic [SEG_W-1:0]  seg_out
);

    localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [LED_W-1:0]  led_q, led_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic [SW_W-1:0]   sw_meta_q, sw_meta_d;
    logic [SW_W-1:0]   sw_sync_q, sw_sync_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              btn_prev_q, btn_prev_d;
    logic              btn_flag_q, btn_flag_d;

    logic sel_led, sel_seg, sel_sw, sel_key, sel_btn, is_io;
    logic mis, rd_io, rd_mem_start, wr_mem, wr_io, btn_rise;
    logic [DATA_W-1:0] io_word, ext_in, ext_out;

    // Address decode and request qualification.
    always_comb begin
        sel_led = (addr_in == DATA_W'(ADDR_LED));
        sel_seg = (addr_in == DATA_W'(ADDR_SEG));
        sel_sw  = (addr_in == DATA_W'(ADDR_SWITCH));
        sel_key = (addr_in == DATA_W'(ADDR_KEY));
        sel_btn = (addr_in == DATA_W'(ADDR_BTN));
        is_io   = sel_led | sel_seg | sel_sw | sel_key | sel_btn;

        mis = (mRead | mWrite | ioRead | ioWrite) & is_misaligned(size, addr_in[1:0]);

        // Any read to an I/O address is an I/O read, whichever strobe is used.
        rd_io        = (mRead | ioRead) & is_io & ~mis & (state_q == ST_IDLE);
        rd_mem_start = mRead & ~is_io & ~mis & (state_q == ST_IDLE);
        wr_mem       = mWrite & ~is_io & ~mis;
        wr_io        = ioWrite & ~mis;
        btn_rise     = conf_btn & ~btn_prev_q;

        io_word = '0;
        if (sel_sw)
            io_word = DATA_W'(sw_sync_q);
        else if (sel_key)
            io_word = DATA_W'(key_q);
        else if (sel_btn)
            io_word = DATA_W'(btn_flag_q);

        ext_in = is_io ? io_word : m_rdata;
    end

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .data_in     (ext_in),
        .byte_off    (addr_in[1:0]),
        .size        (size),
        .is_unsigned (load_unsigned),
        .data_out    (ext_out)
    );

    // Load FSM: the request cycle counts toward the latency, so the capture
    // happens on the MEM_LAT-th stalled cycle and DONE releases the pipeline.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_mem_start) begin
                    if (MEM_LAT == 1) begin
                        cap_d   = ext_out;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = LAT_INIT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_d == 2'd0) begin
                    cap_d   = ext_out;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // I/O register updates, switch synchroniser and sticky button flag.
    always_comb begin
        led_d      = led_q;
        seg_d      = seg_q;
        key_d      = key_q;
        sw_meta_d  = switch_raw;
        sw_sync_d  = sw_meta_q;
        btn_prev_d = conf_btn;
        btn_flag_d = btn_flag_q;
        if (wr_io & sel_led)
            led_d = r_rdata[LED_W-1:0];
        if (wr_io & sel_seg)
            seg_d = r_rdata[SEG_W-1:0];
        if (key_valid)
            key_d = key_data;
        // A new press wins over the clear, so a coincident read never loses it.
        if (btn_rise)
            btn_flag_d = 1'b1;
        else if (rd_io & sel_btn)
            btn_flag_d = 1'b0;
    end

    // Combinational outputs; forced to reset values while rst is high so
    // stall drops immediately even mid-load.
    always_comb begin
        stall    = 1'b0;
        misalign = 1'b0;
        m_be     = 4'b0000;
        r_wdata  = '0;
        case (size)
            SZ_B:    m_wdata = {(DATA_W/8){r_rdata[7:0]}};
            SZ_H:    m_wdata = {(DATA_W/16){r_rdata[15:0]}};
            default: m_wdata = r_rdata;
        endcase
        if (!rst) begin
            stall    = rd_mem_start | (state_q == ST_WAIT);
            misalign = mis;
            if (wr_mem) begin
                case (size)
                    SZ_B:    m_be = 4'b0001 << addr_in[1:0];
                    SZ_H:    m_be = addr_in[1] ? 4'b1100 : 4'b0011;
                    default: m_be = 4'b1111;
                endcase
            end
            if (state_q == ST_DONE)
                r_wdata = cap_q;
            else if (rd_io)
                r_wdata = ext_out;
        end
    end

    // State and register flops.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            cap_q      <= '0;
            led_q      <= '0;
            seg_q      <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            key_q      <= '0;
            btn_prev_q <= 1'b0;
            btn_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_q      <= cap_d;
            led_q      <= led_d;
            seg_q      <= seg_d;
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            key_q      <= key_d;
            btn_prev_q <= btn_prev_d;
            btn_flag_q <= btn_flag_d;
        end
    end

    assign addr_out = {addr_in[DATA_W-1:2], 2'b00};
    assign led_out  = led_q;
    assign seg_out  = seg_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scenario bench for mem_io_bridge with MEM_LAT=2; expectations are queued
// when stimulus is driven and compared against observed DUT outputs.
module tb_mem_io_bridge;

    localparam logic [31:0] A_LED = 32'hFFFF_FC60;
    localparam logic [31:0] A_SEG = 32'hFFFF_FC64;
    localparam logic [31:0] A_SW  = 32'hFFFF_FC70;
    localparam logic [31:0] A_KEY = 32'hFFFF_FC74;
    localparam logic [31:0] A_BTN = 32'hFFFF_FC78;

    logic        clk = 1'b0;
    logic        rst;
    logic        mRead, mWrite, ioRead, ioWrite;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] addr_in, r_rdata, m_rdata;
    logic [11:0] switch_raw;
    logic [3:0]  key_data;
    logic        key_valid, conf_btn;
    logic [31:0] addr_out, m_wdata, r_wdata;
    logic [3:0]  m_be;
    logic        stall, misalign;
    logic [15:0] led_out;
    logic [31:0] seg_out;

    string       exp_n[$];
    logic [31:0] exp_v[$];
    logic [31:0] obs_v[$];
    int          n_cmp = 0;
    int          n_err = 0;

    mem_io_bridge #(.MEM_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .mRead(mRead), .mWrite(mWrite), .ioRead(ioRead), .ioWrite(ioWrite),
        .size(size), .load_unsigned(load_unsigned),
        .addr_in(addr_in), .r_rdata(r_rdata), .m_rdata(m_rdata),
        .switch_raw(switch_raw), .key_data(key_data), .key_valid(key_valid),
        .conf_btn(conf_btn),
        .addr_out(addr_out), .m_wdata(m_wdata), .m_be(m_be), .r_wdata(r_wdata),
        .stall(stall), .misalign(misalign), .led_out(led_out), .seg_out(seg_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic expect_val(input string n, input logic [31:0] v);
        exp_n.push_back(n);
        exp_v.push_back(v);
    endtask

    task automatic observe(input logic [31:0] v);
        obs_v.push_back(v);
    endtask

    task automatic idle_inputs();
        mRead = 0; mWrite = 0; ioRead = 0; ioWrite = 0;
        size = 2'b10; load_unsigned = 0;
    endtask

    // Issues a memory load at a negedge and counts stalled cycles (bounded).
    task automatic mem_load(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                            input logic [31:0] d, output int stalls, output logic [31:0] res);
        stalls = 0;
        mRead = 1; addr_in = a; size = sz; load_unsigned = uns; m_rdata = d;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!stall) break;
            stalls++;
            @(negedge clk);
        end
        res = r_wdata;
        mRead = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] got, want; string nm;
        mRead = 1; addr_in = 32'h10; size = 2'b10;
        #1;
        expect_val("rst_stall", 0);    observe({31'd0, stall});
        expect_val("rst_misalign", 0); observe({31'd0, misalign});
        expect_val("rst_m_be", 0);     observe({28'd0, m_be});
        expect_val("rst_r_wdata", 0);  observe(r_wdata);
        expect_val("rst_led", 0);      observe({16'd0, led_out});
        expect_val("rst_seg", 0);      observe(seg_out);
        mRead = 0;
        while (exp_v.size() != 0) begin
            n_cmp++;
            got = (obs_v.size() != 0) ? obs_v.pop_front() : 'x;
            want = exp_v.pop_front(); nm = exp_n.pop_front();
            if (got !== want) begin n_err++; $display("FAIL %s: got %h expected %h", nm, got, want); end
        end
    endtask

    task automatic test_word_load();
        logic [31:0] got, want, res; string nm; int st;
        expect_val("wload_stall_cycles", 2);
        expect_val("wload_data", 32'h80FF1234);
        mem_load(32'h10, 2'b10, 0, 32'h80FF1234, st, res);
        observe(32'(st)); observe(res);
        #1;
        expect_val("wload_after_stall", 0); observe({31'd0, stall});
        while (exp_v.size() != 0) begin
            n_cmp++;
            got = (obs_v.size() != 0) ? obs_v.pop_front() : 'x;
            want = exp_v.pop_front(); nm = exp_n.pop_front();
            if (got !== want) begin n_err++; $display("FAIL %s: got %h expected %h", nm, got, want); end
        end
        @(negedge clk);
    endtask

    task automatic test_ext_load();
        logic [31:0] got, want, res; string nm; int st;
        expect_val("lb_signed", 32'hFFFFFF80);
        mem_load(32'h13, 2'b00, 0, 32'h80FF1234, st, res); observe(res);
        expect_val("lbu", 32'h00000080);
        mem_load(32'h13, 2'b00, 1, 32'h80FF1234, st, res); observe(res);
        expect_val("lh_upper_signed", 32'hFFFF80FF);
        mem_load(32'h12, 2'b01, 0, 32'h80FF1234, st, res); observe(res);
        expect_val("lb_lane1", 32'h00000012);
        mem_load(32'h11, 2'b00, 0, 32'h80FF1234, st, res); observe(res);
        expect_val("lhu_lower", 32'h00001234);
        mem_load(32'h20, 2'b01, 1, 32'h80FF1234, st, res); observe(res);
        while (exp_v.size() != 0) begin
            n_cmp++;
            got = (obs_v.size() != 0) ? obs_v.pop_front() : 'x;
            want = exp_v.pop_front(); nm = exp_n.pop_front();
            if (got !== want) begin n_err++; $display("FAIL %s: got %h expected %h", nm, got, want); end
        end
    endtask

    task automatic test_store();
        logic [31:0] got, want; string nm;
        for (int k = 0; k < 4; k++) begin
            mWrite = 1; size = 2'b00; addr_in = 32'h20 + 32'(k); r_rdata = 32'h000000AB;
            #1;
            expect_val("sb_be", 32'(4'b0001 << k)); observe({28'd0, m_be});
            expect_val("sb_data", 32'hABABABAB);    observe(m_wdata);
            expect_val("sb_stall", 0);              observe({31'd0, stall});
            expect_val("sb_addr_out", 32'h20);      observe(addr_out);
            @(negedge clk);
        end
        mWrite = 1; size = 2'b01; addr_in = 32'h22; r_rdata = 32'h1234CAFE;
        #1;
        expect_val("sh_be", 32'hC);        observe({28'd0, m_be});
        expect_val("sh_data", 32'hCAFECAFE); observe(m_wdata);
        @(negedge clk);
        mWrite = 1; size = 2'b10; addr_in = 32'h24; r_rdata = 32'hDEADBEEF;
        #1;
        expect_val("sw_be", 32'hF);        observe({28'd0, m_be});
        expect_val("sw_data", 32'hDEADBEEF); observe(m_wdata);
        @(negedge clk);
        mWrite = 0;
        #1;
        expect_val("no_store_be", 0); observe({28'd0, m_be});
        while (exp_v.size() != 0) begin
            n_cmp++;
            got = (obs_v.size() != 0) ? obs_v.pop_front() : 'x;
            want = exp_v.pop_front(); nm = exp_n.pop_front();
            if (got !== want) begin n_err++; $display("FAIL %s: got %h expected %h", nm, got, want); end
        end
        @(negedge clk);
    endtask

    task automatic test_io_write();
        logic [31:0] got, want; string nm;
        ioWrite = 1; size = 2'b10; addr_in = A_LED; r_rdata = 32'h0000BEEF;
        #1;
        expect_val("led_before_edge", 0); observe({16'd0, led_out});
        @(negedge clk);
        ioWrite = 1; addr_in = A_SEG; r_rdata = 32'h12345678;
        #1;
        expect_val("led_written", 32'hBEEF); observe({16'd0, led_out});
        @(negedge clk);
        ioWrite = 1; addr_in = A_SW; r_rdata = 32'hFFFFFFFF;
        #1;
        expect_val("seg_written", 32'h12345678); observe(seg_out);
        expect_val("led_kept", 32'hBEEF);        observe({16'd0, led_out});
        @(negedge clk);
        ioWrite = 0; mWrite = 1; addr_in = A_LED; r_rdata = 32'h00001111;
        #1;
        expect_val("mwrite_io_be", 0);          observe({28'd0, m_be});
        expect_val("seg_after_ignored", 32'h12345678); observe(seg_out);
        @(negedge clk);
        mWrite = 0;
        #1;
        expect_val("led_after_mwrite", 32'hBEEF); observe({16'd0, led_out});
        while (exp_v.size() != 0) begin
            n_cmp++;
            got = (obs_v.size() != 0) ? obs_v.pop_front() : 'x;
            want = exp_v.pop_front(); nm = exp_n.pop_front();
            if (got !== want) begin n_err++; $display("FAIL %s: got %h expected %h", nm, got, want); end
        end
        @(negedge clk);
    endtask

    task automatic test_key_switch();
        logic [31:0] got, want; string nm;
        switch_raw = 12'hABC; ioRead = 1; size = 2'b10; addr_in = A_SW;
        #1;
        expect_val("sw_sync_0", 0); observe(r_wdata);
        @(negedge clk); #1;
        expect_val("sw_sync_1", 0); observe(r_wdata);
        @(negedge clk); #1;
        expect_val("sw_sync_2", 32'hABC); observe(r_wdata);
        @(negedge clk);
        ioRead = 1; mRead = 1;
        #1;
        expect_val("mread_io_data", 32'hABC); observe(r_wdata);
        expect_val("mread_io_stall", 0);      observe({31'd0, stall});
        @(negedge clk);
        ioRead = 0; mRead = 0; key_data = 4'h9; key_valid = 1;
        @(negedge clk);
        key_valid = 0; key_data = 4'h3; ioRead = 1; addr_in = A_KEY;
        #1;
        expect_val("key_latched", 32'h9); observe(r_wdata);
        @(negedge clk);
        ioRead = 0;
        while (exp_v.size() != 0) begin
            n_cmp++;
            got = (obs_v.size() != 0) ? obs_v.pop_front() : 'x;
            want = exp_v.pop_front(); nm = exp_n.pop_front();
            if (got !== want) begin n_err++; $display("FAIL %s: got %h expected %h", nm, got, want); end
        end
    endtask

    task automatic test_btn();
        logic [31:0] got, want; string nm;
        conf_btn = 1;
        @(negedge clk);
        conf_btn = 0; ioRead = 1; size = 2'b10; addr_in = A_BTN;
        #1; expect_val("btn_read_set", 1); observe(r_wdata);
        @(negedge clk);
        #1; expect_val("btn_read_cleared", 0); observe(r_wdata);
        @(negedge clk);
        conf_btn = 1;
        #1; expect_val("btn_coincident_old", 0); observe(r_wdata);
        @(negedge clk);
        conf_btn = 0;
        #1; expect_val("btn_coincident_kept", 1); observe(r_wdata);
        @(negedge clk);
        #1; expect_val("btn_final_clear", 0); observe(r_wdata);
        @(negedge clk);
        ioRead = 0;
        while (exp_v.size() != 0) begin
            n_cmp++;
            got = (obs_v.size() != 0) ? obs_v.pop_front() : 'x;
            want = exp_v.pop_front(); nm = exp_n.pop_front();
            if (got !== want) begin n_err++; $display("FAIL %s: got %h expected %h", nm, got, want); end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] got, want; string nm;
        mRead = 1; size = 2'b10; addr_in = 32'h6; m_rdata = 32'h80FF1234;
        #1;
        expect_val("mis_flag", 1);   observe({31'd0, misalign});
        expect_val("mis_stall", 0);  observe({31'd0, stall});
        expect_val("mis_rdata", 0);  observe(r_wdata);
        @(negedge clk);
        mRead = 0;
        #1;
        expect_val("mis_one_cycle", 0); observe({31'd0, misalign});
        expect_val("mis_no_wait", 0);   observe({31'd0, stall});
        @(negedge clk);
        mWrite = 1; size = 2'b01; addr_in = 32'h21; r_rdata = 32'h5555;
        #1;
        expect_val("mis_half_be", 0);   observe({28'd0, m_be});
        expect_val("mis_half_flag", 1); observe({31'd0, misalign});
        @(negedge clk);
        mWrite = 0; ioRead = 1; size = 2'b10; addr_in = 32'h100;
        #1;
        expect_val("unmatched_read", 0); observe(r_wdata);
        @(negedge clk);
        ioRead = 0;
        while (exp_v.size() != 0) begin
            n_cmp++;
            got = (obs_v.size() != 0) ? obs_v.pop_front() : 'x;
            want = exp_v.pop_front(); nm = exp_n.pop_front();
            if (got !== want) begin n_err++; $display("FAIL %s: got %h expected %h", nm, got, want); end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] got, want; string nm;
        mRead = 1; size = 2'b10; addr_in = 32'h40; m_rdata = 32'h55;
        #1; expect_val("pre_rst_stall_idle", 1); observe({31'd0, stall});
        @(negedge clk);
        #1; expect_val("pre_rst_stall_wait", 1); observe({31'd0, stall});
        rst = 1;
        #1;
        expect_val("rst_wait_stall", 0);   observe({31'd0, stall});
        expect_val("rst_wait_rdata", 0);   observe(r_wdata);
        expect_val("rst_wait_led", 0);     observe({16'd0, led_out});
        expect_val("rst_wait_seg", 0);     observe(seg_out);
        expect_val("rst_wait_be", 0);      observe({28'd0, m_be});
        mRead = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        #1; expect_val("post_rst_idle", 0); observe({31'd0, stall});
        while (exp_v.size() != 0) begin
            n_cmp++;
            got = (obs_v.size() != 0) ? obs_v.pop_front() : 'x;
            want = exp_v.pop_front(); nm = exp_n.pop_front();
            if (got !== want) begin n_err++; $display("FAIL %s: got %h expected %h", nm, got, want); end
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        addr_in = '0; r_rdata = '0; m_rdata = '0;
        switch_raw = '0; key_data = '0; key_valid = 0; conf_btn = 0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 0;
        @(negedge clk);
        test_word_load();
        test_ext_load();
        test_store();
        test_io_write();
        test_key_switch();
        test_btn();
        test_misalign();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
